// File: rtl/window_router_pkg.sv
// ============================================================================
// Module : window_router_pkg
// Brief  : Shared geometry, mode type and helper functions for window_router.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package window_router_pkg;

  localparam int DW    = 32;
  localparam int POY   = 3;
  localparam int POX   = 16;
  localparam int KSIZE = 3;
  localparam int SMAX  = 2;
  localparam int BUFW  = (POX - 1) * SMAX + KSIZE;
  localparam int NROW  = (POY - 1) * SMAX + KSIZE;
  localparam int NTAP  = KSIZE * KSIZE;
  localparam int IDXW  = $clog2(NTAP);
  localparam int KW    = $clog2(KSIZE);

  typedef enum logic {MODE_DW = 1'b0, MODE_PW = 1'b1} mode_e;

  function automatic logic stride_illegal(input logic [1:0] s);
    return (s == 2'd0) || (int'(s) > SMAX);
  endfunction

  function automatic logic [1:0] clamp_stride(input logic [1:0] s);
    if (s == 2'd0) return 2'd1;
    if (int'(s) > SMAX) return 2'(SMAX);
    return s;
  endfunction

  function automatic int pix_off(input int r, input int c);
    return (r * BUFW + c) * DW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_tap_gen.sv
// ============================================================================
// Module : window_tap_gen
// Brief  : Beat sequencer; presents the tap/column of the beat about to load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module window_tap_gen
  import window_router_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            mode,
  output logic [IDXW-1:0] nxt_idx,
  output logic [KW-1:0]   nxt_ky,
  output logic [KW-1:0]   nxt_kx,
  output logic            nxt_first,
  output logic            nxt_last
);

  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   ky_q, ky_d, kx_q, kx_d;

  always_comb begin
    nxt_idx = cnt_q + 1'b1;
    if (kx_q == KW'(KSIZE - 1)) begin
      nxt_kx = '0;
      nxt_ky = ky_q + 1'b1;
    end else begin
      nxt_kx = kx_q + 1'b1;
      nxt_ky = ky_q;
    end
    if (start) begin
      nxt_idx = '0;
      nxt_kx  = '0;
      nxt_ky  = '0;
    end
    nxt_first = start;
    nxt_last  = (mode == MODE_PW) ? (nxt_idx == IDXW'(POX - 1))
                                  : (nxt_idx == IDXW'(NTAP - 1));
    cnt_d = cnt_q;
    ky_d  = ky_q;
    kx_d  = kx_q;
    if (start || step) begin
      cnt_d = nxt_idx;
      ky_d  = nxt_ky;
      kx_d  = nxt_kx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ky_q  <= '0;
      kx_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ky_q  <= ky_d;
      kx_q  <= kx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_router.sv
// ============================================================================
// Module : window_router
// Brief  : Captures a line-buffer tile and streams DW tap slices / PW columns.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module window_router
  import window_router_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NROW*BUFW*DW-1:0] in_data,
  input  logic                    in_mode,
  input  logic [1:0]              in_stride,
  input  logic                    in_blkend,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [POY*POX*DW-1:0]   dw_pix,
  output logic [POY*DW-1:0]       pw_pix,
  output logic                    out_mode,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    out_blkend,
  output logic                    cfg_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [NROW*BUFW*DW-1:0]   tile_q, tile_d;
  logic                      mode_q, mode_d, blkend_q, blkend_d, cfg_err_q, cfg_err_d;
  logic [1:0]                stride_q, stride_d;
  logic                      out_valid_q, out_valid_d, out_mode_q, out_mode_d;
  logic                      out_first_q, out_first_d, out_last_q, out_last_d;
  logic                      out_blkend_q, out_blkend_d;
  logic [IDXW-1:0]           out_idx_q, out_idx_d;
  logic [POY*POX*DW-1:0]     dw_pix_q, dw_pix_d;
  logic [POY*DW-1:0]         pw_pix_q, pw_pix_d;

  logic                      w_hs, w_last_hs, w_accept, w_step, w_load;
  logic [NROW*BUFW*DW-1:0]   w_tile;
  logic                      w_mode, w_blkend, w_first, w_last;
  logic [1:0]                w_stride;
  int                        w_s;
  logic [IDXW-1:0]           w_idx;
  logic [KW-1:0]             w_ky, w_kx;
  logic [POY*POX*DW-1:0]     w_dw_slice;
  logic [POY*DW-1:0]         w_pw_col;

  assign w_hs      = out_valid_q & out_ready;
  assign w_last_hs = w_hs & out_last_q;
  assign in_ready  = (state_q == ST_IDLE) | w_last_hs;
  assign w_accept  = in_valid & in_ready;
  assign w_step    = w_hs & ~out_last_q;
  assign w_load    = w_accept | w_step;

  // On accept the first beat is built straight from the incoming tile.
  assign w_tile   = w_accept ? in_data : tile_q;
  assign w_mode   = w_accept ? in_mode : mode_q;
  assign w_blkend = w_accept ? in_blkend : blkend_q;
  assign w_stride = w_accept ? clamp_stride(in_stride) : stride_q;
  assign w_s      = int'(w_stride);

  window_tap_gen u_tap_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (w_accept),
    .step      (w_step),
    .mode      (w_mode),
    .nxt_idx   (w_idx),
    .nxt_ky    (w_ky),
    .nxt_kx    (w_kx),
    .nxt_first (w_first),
    .nxt_last  (w_last)
  );

  for (genvar y = 0; y < POY; y++) begin : g_y
    for (genvar x = 0; x < POX; x++) begin : g_x
      assign w_dw_slice[(y*POX+x)*DW +: DW] =
        w_tile[pix_off(y*w_s + int'(w_ky), x*w_s + int'(w_kx)) +: DW];
    end
    assign w_pw_col[y*DW +: DW] = w_tile[pix_off(y*w_s, int'(w_idx)*w_s) +: DW];
  end

  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    mode_d       = mode_q;
    stride_d     = stride_q;
    blkend_d     = blkend_q;
    cfg_err_d    = cfg_err_q;
    dw_pix_d     = dw_pix_q;
    pw_pix_d     = pw_pix_q;
    out_mode_d   = out_mode_q;
    out_idx_d    = out_idx_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    out_blkend_d = out_blkend_q;

    case (state_q)
      ST_IDLE:   if (w_accept) state_d = ST_STREAM;
      ST_STREAM: if (w_last_hs) state_d = w_accept ? ST_STREAM : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      tile_d    = in_data;
      mode_d    = in_mode;
      stride_d  = clamp_stride(in_stride);
      blkend_d  = in_blkend;
      cfg_err_d = cfg_err_q | stride_illegal(in_stride);
    end

    if (w_load) begin
      dw_pix_d     = (w_mode == MODE_DW) ? w_dw_slice : '0;
      pw_pix_d     = (w_mode == MODE_PW) ? w_pw_col : '0;
      out_mode_d   = w_mode;
      out_idx_d    = w_idx;
      out_first_d  = w_first;
      out_last_d   = w_last;
      out_blkend_d = w_last & w_blkend;
    end

    out_valid_d = (state_d == ST_STREAM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tile_q       <= '0;
      mode_q       <= 1'b0;
      stride_q     <= 2'd1;
      blkend_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      dw_pix_q     <= '0;
      pw_pix_q     <= '0;
      out_mode_q   <= 1'b0;
      out_idx_q    <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_blkend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      mode_q       <= mode_d;
      stride_q     <= stride_d;
      blkend_q     <= blkend_d;
      cfg_err_q    <= cfg_err_d;
      out_valid_q  <= out_valid_d;
      dw_pix_q     <= dw_pix_d;
      pw_pix_q     <= pw_pix_d;
      out_mode_q   <= out_mode_d;
      out_idx_q    <= out_idx_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      out_blkend_q <= out_blkend_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign dw_pix     = dw_pix_q;
  assign pw_pix     = pw_pix_q;
  assign out_mode   = out_mode_q;
  assign out_idx    = out_idx_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign out_blkend = out_blkend_q;
  assign cfg_err    = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_window_router.sv
// ============================================================================
// Module : tb_window_router
// Brief  : Directed + randomized bench for window_router with a tile-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_window_router;
  import window_router_pkg::*;

  localparam int WIDE = POY * POX * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_mode = 1'b0, in_blkend = 1'b0, out_ready = 1'b0;
  logic [NROW*BUFW*DW-1:0] in_data = '0;
  logic [1:0] in_stride = 2'd1;
  logic in_ready, out_valid, out_mode, out_first, out_last, out_blkend, cfg_err;
  logic [WIDE-1:0] dw_pix;
  logic [POY*DW-1:0] pw_pix;
  logic [IDXW-1:0] out_idx;

  window_router dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_stride(in_stride), .in_blkend(in_blkend),
    .out_valid(out_valid), .out_ready(out_ready), .dw_pix(dw_pix), .pw_pix(pw_pix),
    .out_mode(out_mode), .out_idx(out_idx), .out_first(out_first), .out_last(out_last),
    .out_blkend(out_blkend), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int nxt_pix[NROW][BUFW];
  int cur_pix[NROW][BUFW];
  int nxt_mode, nxt_s, nxt_raw, nxt_blk;
  int cur_mode, cur_s, cur_blk;
  int snap_k;
  logic [WIDE-1:0] snap_dw;
  logic [POY*DW-1:0] snap_pw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [WIDE-1:0] obs, input logic [WIDE-1:0] exp);
    int bad;
    bad = -1;
    for (int i = WIDE/DW - 1; i >= 0; i--)
      if (obs[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: pixel slot %0d observed %0d expected %0d", tag, bad,
             obs[bad*DW +: DW], exp[bad*DW +: DW]);
    end
  endtask

  // Reference: every beat is a plain lookup into the captured tile.
  function automatic logic [WIDE-1:0] exp_dw(input int k);
    logic [WIDE-1:0] v;
    v = '0;
    if (cur_mode == 0)
      for (int y = 0; y < POY; y++)
        for (int x = 0; x < POX; x++)
          v[(y*POX+x)*DW +: DW] = cur_pix[y*cur_s + k/KSIZE][x*cur_s + k%KSIZE];
    return v;
  endfunction

  function automatic logic [WIDE-1:0] exp_pw(input int k);
    logic [WIDE-1:0] v;
    v = '0;
    if (cur_mode == 1)
      for (int y = 0; y < POY; y++)
        v[y*DW +: DW] = cur_pix[y*cur_s][k*cur_s];
    return v;
  endfunction

  task automatic set_tile(input int kind, input int mode, input int raw_s, input int blk);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < BUFW; c++)
        nxt_pix[r][c] = (kind == 0) ? r*100 + c : int'($urandom);
    nxt_mode = mode;
    nxt_raw  = raw_s;
    nxt_s    = (raw_s == 0) ? 1 : (raw_s > SMAX ? SMAX : raw_s);
    nxt_blk  = blk;
  endtask

  task automatic drive_next();
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < BUFW; c++)
        in_data[(r*BUFW+c)*DW +: DW] = nxt_pix[r][c];
    in_mode   = nxt_mode[0];
    in_stride = nxt_raw[1:0];
    in_blkend = nxt_blk[0];
    in_valid  = 1'b1;
  endtask

  task automatic promote();
    cur_pix  = nxt_pix;
    cur_mode = nxt_mode;
    cur_s    = nxt_s;
    cur_blk  = nxt_blk;
    in_valid = 1'b0;
    in_data  = ~in_data;
  endtask

  task automatic offer_idle();
    @(negedge clk);
    drive_next();
    #1 chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 promote();
  endtask

  // pat: 0 always ready, 1 repeating 1-0-0-1, 2 random. abort_k >= 0 pulses rst on that beat.
  task automatic stream(input int pat, input bit chain, input int abort_k);
    int nb, k, cyc;
    bit stalled, done;
    logic [WIDE-1:0] p_dw;
    logic [POY*DW-1:0] p_pw;
    logic [IDXW-1:0] p_idx;
    nb = (cur_mode == 1) ? POX : NTAP;
    k = 0; cyc = 0; stalled = 0; done = 0;
    p_dw = '0; p_pw = '0; p_idx = '0;
    while (!done) begin
      @(negedge clk);
      case (pat)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) chk("first_beat_latency", out_valid, 1);
      if (abort_k >= 0 && k == abort_k) begin
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_idx", out_idx, 0);
        chk_w("rst_dw_pix", dw_pix, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_beat", out_valid, 0);
        return;
      end
      chk("out_valid_streaming", out_valid, 1);
      if (out_valid) begin
        if (stalled) begin
          chk_w("stall_dw_stable", dw_pix, p_dw);
          chk_w("stall_pw_stable", WIDE'(pw_pix), WIDE'(p_pw));
          chk("stall_idx_stable", out_idx, p_idx);
        end
        chk("beat_mode", out_mode, cur_mode);
        chk("beat_idx", out_idx, k);
        chk("beat_first", out_first, k == 0);
        chk("beat_last", out_last, k == nb - 1);
        chk("beat_blkend", out_blkend, (k == nb - 1) && cur_blk != 0);
        chk_w("beat_dw_pix", dw_pix, exp_dw(k));
        chk_w("beat_pw_pix", WIDE'(pw_pix), exp_pw(k));
        if (k == snap_k) begin
          snap_dw = dw_pix;
          snap_pw = pw_pix;
        end
        if (!(k == nb - 1 && out_ready)) chk("in_ready_busy", in_ready, 0);
        p_dw = dw_pix; p_pw = pw_pix; p_idx = out_idx;
        if (out_ready) begin
          if (k == nb - 1 && chain) begin
            drive_next();
            #1 chk("in_ready_last_beat", in_ready, 1);
          end
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
        end
      end
      cyc++;
      if (k == nb) done = 1;
      if (cyc > 400) begin
        chk("stream_timeout", 0, 1);
        done = 1;
      end
    end
    if (chain) begin
      @(posedge clk);
      #1 promote();
    end else begin
      @(negedge clk);
      chk("idle_after_last", out_valid, 0);
    end
  endtask

  initial begin
    snap_k = -1;
    snap_dw = '0;
    snap_pw = '0;
    cur_mode = 0; cur_s = 1; cur_blk = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_out_first", out_first, 0);
    chk("reset_out_idx", out_idx, 0);
    chk_w("reset_dw_pix", dw_pix, '0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_beat", out_valid, 0);
    end

    // DW stride 1, ramp tile
    set_tile(0, 0, 1, 0);
    offer_idle();
    snap_k = 4;
    stream(0, 0, -1);
    chk("dw_s1_idx4_pix_2_5", snap_dw[(2*POX+5)*DW +: DW], 306);
    chk("cfg_err_legal", cfg_err, 0);

    // DW stride 2, block end
    set_tile(0, 0, 2, 1);
    offer_idle();
    snap_k = 8;
    stream(0, 0, -1);
    chk("dw_s2_idx8_pix_1_3", snap_dw[(1*POX+3)*DW +: DW], 408);
    chk("dw_s2_idx8_pix_2_15", snap_dw[(2*POX+15)*DW +: DW], 632);

    set_tile(0, 0, 2, 0);
    offer_idle();
    stream(0, 0, -1);

    // PW stride 1 followed by a back-to-back random DW tile
    set_tile(0, 1, 1, 0);
    offer_idle();
    snap_k = 7;
    set_tile(1, 0, 1, 1);
    stream(0, 1, -1);
    chk("pw_s1_x7_y0", snap_pw[0*DW +: DW], 7);
    chk("pw_s1_x7_y1", snap_pw[1*DW +: DW], 107);
    chk("pw_s1_x7_y2", snap_pw[2*DW +: DW], 207);
    snap_k = -1;
    stream(2, 0, -1);

    // Backpressure 1-0-0-1
    set_tile(1, 0, 1, 0);
    offer_idle();
    stream(1, 0, -1);

    // Random PW stride 2 with random ready
    set_tile(1, 1, 2, 1);
    offer_idle();
    stream(2, 0, -1);
    chk("cfg_err_still_clear", cfg_err, 0);

    // Illegal strides: 3 behaves as 2, 0 behaves as 1
    set_tile(1, 0, 3, 0);
    offer_idle();
    stream(2, 0, -1);
    chk("cfg_err_stride3", cfg_err, 1);
    set_tile(1, 1, 0, 0);
    offer_idle();
    stream(0, 0, -1);
    chk("cfg_err_sticky", cfg_err, 1);

    // Reset mid-tile on beat 4
    set_tile(1, 0, 1, 0);
    offer_idle();
    stream(0, 0, 4);

    // Recovery after reset
    set_tile(0, 0, 1, 1);
    offer_idle();
    stream(0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
